inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage's `pc` and the external instruction memory. It returns `inst` and `hit` combinationally on a hit. On a miss it raises `freeze` so the fetch stage holds `pc`, refills the whole line with a multi-beat burst, then serves the fetch. With `cache_en` low it performs single-word uncached reads and does not allocate.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_data_array.sv | 31 +++
 rtl/inst_cache.sv | 180 ++++++++++++++++++
 tb/tb_inst_cache.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Widths are derived from the LINES/WORDS parameters of the instantiating module.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        UNCACHED = 2'd2,
        BYPASS   = 2'd3
    } icache_state_t;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    function automatic int unsigned off_w(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Everything above the byte offset, word offset and index is tag.
    function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
        return ADDR_W - 2 - off_w(words) - idx_w(lines);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction data storage: LINES x WORDS x 32 bits, one combinational read port
// and one synchronous write port.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk_i,
    input  logic [idx_w(LINES)-1:0]    rd_idx_i,
    input  logic [off_w(WORDS)-1:0]    rd_off_i,
    output logic [DATA_W-1:0]          rd_data_o,
    input  logic                       we_i,
    input  logic [idx_w(LINES)-1:0]    wr_idx_i,
    input  logic [off_w(WORDS)-1:0]    wr_off_i,
    input  logic [DATA_W-1:0]          wr_data_i
);

    localparam int unsigned Depth = LINES * WORDS;

    logic [DATA_W-1:0] mem_q [Depth];

    assign rd_data_o = mem_q[{rd_idx_i, rd_off_i}];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, burst line refill on
// miss, and single-word uncached reads through a one-cycle bypass register.
module inst_cache
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        cache_en,
    input  logic        invalidate,
    output logic [31:0] inst,
    output logic        hit,
    output logic        freeze,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_single,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int unsigned OFF_W = off_w(WORDS);
    localparam int unsigned IDX_W = idx_w(LINES);
    localparam int unsigned TAG_W = tag_w(LINES, WORDS);
    localparam int unsigned LSB_W = OFF_W + 2;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc;

    assign pc_off    = pc[LSB_W-1:2];
    assign pc_idx    = pc[LSB_W+IDX_W-1:LSB_W];
    assign pc_tag    = pc[31:LSB_W+IDX_W];
    assign unused_pc = ^pc[1:0];

    icache_state_t    state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [31:0]      bypass_q, bypass_d;
    logic             pend_inv_q, pend_inv_d;
    logic [TAG_W-1:0] tag_q [LINES];

    logic        lookup_hit;
    logic        beat_we;
    logic        last_beat;
    logic [31:0] rd_data;

    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign beat_we    = (state_q == REFILL) && mem_rvalid;
    assign last_beat  = beat_we && (cnt_q == OFF_W'(WORDS - 1));

    icache_data_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_data (
        .clk_i     (clk),
        .rd_idx_i  (pc_idx),
        .rd_off_i  (pc_off),
        .rd_data_o (rd_data),
        .we_i      (beat_we),
        .wr_idx_i  (pc_idx),
        .wr_off_i  (cnt_q),
        .wr_data_i (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        bypass_d   = bypass_q;
        pend_inv_d = pend_inv_q;
        if (invalidate) begin
            valid_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (!cache_en) begin
                    state_d = UNCACHED;
                end else if (!lookup_hit) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (invalidate) begin
                    pend_inv_d = 1'b1;
                end
                if (mem_rvalid) begin
                    cnt_d = cnt_q + OFF_W'(1);
                end
                // An invalidate seen at any point of the burst leaves the new line invalid.
                if (last_beat) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    pend_inv_d = 1'b0;
                    if (!(pend_inv_q || invalidate)) begin
                        valid_d[pc_idx] = 1'b1;
                    end
                end
            end
            UNCACHED: begin
                if (mem_rvalid) begin
                    bypass_d = mem_rdata;
                    state_d  = BYPASS;
                end
            end
            BYPASS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            cnt_q      <= '0;
            bypass_q   <= '0;
            pend_inv_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            bypass_q   <= bypass_d;
            pend_inv_q <= pend_inv_d;
        end
    end

    // Tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_q[pc_idx] <= pc_tag;
        end
    end

    always_comb begin
        inst       = '0;
        hit        = 1'b0;
        freeze     = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_single = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (cache_en && lookup_hit) begin
                        hit  = 1'b1;
                        inst = rd_data;
                    end else begin
                        freeze = 1'b1;
                    end
                end
                REFILL: begin
                    freeze   = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {pc[31:LSB_W], {LSB_W{1'b0}}};
                end
                UNCACHED: begin
                    freeze     = 1'b1;
                    mem_req    = 1'b1;
                    mem_single = 1'b1;
                    mem_addr   = {pc[31:2], 2'b00};
                end
                BYPASS: begin
                    hit  = 1'b1;
                    inst = bypass_q;
                end
                default: begin
                    freeze = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: a table of fetches with expected stall counts and
// request attributes, a scoreboard of expected words, and hand-written corner sequences.
module tb_inst_cache;

    localparam int WORDS = 4;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        cache_en;
    logic        invalidate;
    logic [31:0] inst;
    logic        hit;
    logic        freeze;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_single;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int total = 0;
    int bad   = 0;
    int cur_beat;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] pc;
        logic        en;
        int          stalls;
        logic [31:0] addr;
        logic        single;
    } vec_t;

    vec_t vecs [17];

    inst_cache #(
        .LINES (16),
        .WORDS (WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .cache_en   (cache_en),
        .invalidate (invalidate),
        .inst       (inst),
        .hit        (hit),
        .freeze     (freeze),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_single (mem_single),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Memory: LAT idle cycles after mem_req rises, then ascending beats every cycle.
    initial begin
        int beat;
        int wcnt;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        cur_beat   = 0;
        beat       = 0;
        wcnt       = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !mem_req) begin
                mem_rvalid = 1'b0;
                beat       = 0;
                wcnt       = 0;
            end else if (wcnt < LAT) begin
                wcnt++;
                mem_rvalid = 1'b0;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(mem_addr + 32'(4 * beat));
                cur_beat   = beat;
                beat++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one fetch and hold it until the cache reports a hit.
    task automatic do_access(input logic [31:0] a, input logic en, output int stalls,
                             output logic [31:0] addr_seen, output logic single_seen);
        bit got;
        bit req_seen;
        logic [31:0] e;
        pc          = a;
        cache_en    = en;
        exp_q.push_back(mem_word(a));
        stalls      = 0;
        addr_seen   = '0;
        single_seen = 1'b0;
        got         = 1'b0;
        req_seen    = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (hit) begin
                got = 1'b1;
                chk("hit_freeze", 32'(freeze), 32'd0);
                chk("hit_mem_req", 32'(mem_req), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst", inst, e);
                end
            end else begin
                stalls++;
                if (mem_req && !req_seen) begin
                    req_seen    = 1'b1;
                    addr_seen   = mem_addr;
                    single_seen = mem_single;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("access_done", 32'(got), 32'd1);
        if (!got) exp_q.delete();
    endtask

    task automatic run_access(input string tag, input logic [31:0] a, input logic en,
                              input int exp_stalls, input logic [31:0] exp_addr,
                              input logic exp_single);
        int          st;
        logic [31:0] ad;
        logic        sg;
        do_access(a, en, st, ad, sg);
        chk({tag, "_stalls"}, 32'(st), 32'(exp_stalls));
        chk({tag, "_addr"}, ad, exp_addr);
        chk({tag, "_single"}, 32'(sg), 32'(exp_single));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        bit sent;
        bit saw_hit;

        vecs[0]  = '{32'h0000_0100, 1'b1, 7, 32'h0000_0100, 1'b0};
        vecs[1]  = '{32'h0000_0104, 1'b1, 0, 32'h0,         1'b0};
        vecs[2]  = '{32'h0000_0108, 1'b1, 0, 32'h0,         1'b0};
        vecs[3]  = '{32'h0000_010C, 1'b1, 0, 32'h0,         1'b0};
        vecs[4]  = '{32'h0000_1100, 1'b1, 7, 32'h0000_1100, 1'b0};
        vecs[5]  = '{32'h0000_1104, 1'b1, 0, 32'h0,         1'b0};
        vecs[6]  = '{32'h0000_0100, 1'b1, 7, 32'h0000_0100, 1'b0};
        vecs[7]  = '{32'h0000_0204, 1'b0, 4, 32'h0000_0204, 1'b1};
        vecs[8]  = '{32'h0000_0204, 1'b1, 7, 32'h0000_0200, 1'b0};
        vecs[9]  = '{32'h0000_0208, 1'b1, 0, 32'h0,         1'b0};
        vecs[10] = '{32'h0000_01FC, 1'b1, 7, 32'h0000_01F0, 1'b0};
        vecs[11] = '{32'h0000_01F0, 1'b1, 0, 32'h0,         1'b0};
        vecs[12] = '{32'h0000_00F4, 1'b1, 7, 32'h0000_00F0, 1'b0};
        vecs[13] = '{32'h0000_01F8, 1'b1, 7, 32'h0000_01F0, 1'b0};
        vecs[14] = '{32'h8000_0104, 1'b1, 7, 32'h8000_0100, 1'b0};
        vecs[15] = '{32'h8000_010C, 1'b1, 0, 32'h0,         1'b0};
        vecs[16] = '{32'h0000_0104, 1'b1, 7, 32'h0000_0100, 1'b0};

        rst        = 1'b1;
        pc         = 32'h100;
        cache_en   = 1'b1;
        invalidate = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_single", 32'(mem_single), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].pc, vecs[i].en, vecs[i].stalls,
                       vecs[i].addr, vecs[i].single);
        end

        // Invalidate pulse on beat 2 of a refill.
        pc       = 32'h300;
        cache_en = 1'b1;
        done     = 1'b0;
        sent     = 1'b0;
        saw_hit  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (hit) saw_hit = 1'b1;
            if (mem_rvalid && cur_beat == 2 && !sent) begin
                invalidate = 1'b1;
                sent       = 1'b1;
            end
            if (mem_rvalid && cur_beat == WORDS - 1) done = 1'b1;
            @(posedge clk);
            #1;
            invalidate = 1'b0;
        end
        chk("inv_refill_done", 32'(done), 32'd1);
        chk("inv_refill_no_hit", 32'(saw_hit), 32'd0);
        run_access("inv_same_pc", 32'h300, 1'b1, 7, 32'h300, 1'b0);
        run_access("inv_other_line", 32'h1F0, 1'b1, 7, 32'h1F0, 1'b0);

        // Reset on beat 1 of a refill.
        pc   = 32'h400;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_rvalid && cur_beat == 1) begin
                done = 1'b1;
                rst  = 1'b1;
                #1;
                chk("mrst_mem_req", 32'(mem_req), 32'd0);
                chk("mrst_freeze", 32'(freeze), 32'd0);
                chk("mrst_hit", 32'(hit), 32'd0);
                chk("mrst_mem_addr", mem_addr, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        chk("mrst_reached", 32'(done), 32'd1);
        rst = 1'b0;
        run_access("mrst_same_pc", 32'h400, 1'b1, 7, 32'h400, 1'b0);

        // Invalidate in IDLE: this cycle's hit stands, the next cycle misses.
        pc         = 32'h404;
        invalidate = 1'b1;
        @(negedge clk);
        chk("idle_inv_hit", 32'(hit), 32'd1);
        chk("idle_inv_inst", inst, mem_word(32'h404));
        @(posedge clk);
        #1;
        invalidate = 1'b0;
        @(negedge clk);
        chk("idle_inv_after_hit", 32'(hit), 32'd0);
        chk("idle_inv_after_freeze", 32'(freeze), 32'd1);
        @(posedge clk);
        #1;
        run_access("idle_inv_refill", 32'h404, 1'b1, 6, 32'h400, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
